// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS32 core.
// Also detects load-use hazards and counts the stall cycles they cause.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [5:0]        id_opcode,
  input  logic [5:0]        id_funct,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [8:0]        id_ctrl,
  input  logic              flush,
  input  logic              stall_cnt_clr,
  output logic [5:0]        ID_EX_OPcode,
  output logic [5:0]        ID_EX_funct,
  output logic [4:0]        ID_EX_rs,
  output logic [4:0]        ID_EX_rt,
  output logic [4:0]        ID_EX_rd,
  output logic [4:0]        ID_EX_wreg,
  output logic [DATA_W-1:0] ID_EX_rdata1,
  output logic [DATA_W-1:0] ID_EX_rdata2,
  output logic [DATA_W-1:0] ID_EX_imm,
  output logic [8:0]        ID_EX_ctrl,
  output logic              ID_EX_valid,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  // Opcodes that read rt as a source operand
  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_BEQ   = 6'b000100,
    OP_BNE   = 6'b000101,
    OP_SW    = 6'b101011
  } opc_e;

  // id_ctrl packing: {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, Branch, ALUOp[1:0]}
  localparam int unsigned CTRL_MEMREAD = 7;
  localparam int unsigned CTRL_REGDST  = 3;

  logic [5:0]        r_opcode;
  logic [5:0]        r_funct;
  logic [4:0]        r_rs;
  logic [4:0]        r_rt;
  logic [4:0]        r_rd;
  logic [4:0]        r_wreg;
  logic [DATA_W-1:0] r_rdata1;
  logic [DATA_W-1:0] r_rdata2;
  logic [DATA_W-1:0] r_imm;
  logic [8:0]        r_ctrl;
  logic              r_valid;
  logic [CNT_W-1:0]  r_cnt;

  logic w_uses_rt;
  logic w_haz;
  logic w_stall;
  logic w_load;

  always_comb begin
    w_uses_rt = 1'b0;
    case (id_opcode)
      OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: w_uses_rt = 1'b1;
      default:                         w_uses_rt = 1'b0;
    endcase
  end

  // $0 is hard-wired zero, so a load targeting it never creates a dependency
  always_comb begin
    w_haz = r_ctrl[CTRL_MEMREAD] && (r_rt != '0) && id_valid &&
            ((r_rt == id_rs) || (w_uses_rt && (r_rt == id_rt)));
  end

  assign w_stall = w_haz & ~flush;
  assign w_load  = id_valid & ~flush & ~w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode <= '0;
      r_funct  <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_rd     <= '0;
      r_wreg   <= '0;
      r_rdata1 <= '0;
      r_rdata2 <= '0;
      r_imm    <= '0;
      r_ctrl   <= '0;
      r_valid  <= 1'b0;
    end else if (w_load) begin
      r_opcode <= id_opcode;
      r_funct  <= id_funct;
      r_rs     <= id_rs;
      r_rt     <= id_rt;
      r_rd     <= id_rd;
      r_wreg   <= id_ctrl[CTRL_REGDST] ? id_rd : id_rt;
      r_rdata1 <= id_rdata1;
      r_rdata2 <= id_rdata2;
      r_imm    <= id_imm;
      r_ctrl   <= id_ctrl;
      r_valid  <= 1'b1;
    end else begin
      // flush, stall and empty ID slot all collapse to the same bubble
      r_opcode <= '0;
      r_funct  <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_rd     <= '0;
      r_wreg   <= '0;
      r_rdata1 <= '0;
      r_rdata2 <= '0;
      r_imm    <= '0;
      r_ctrl   <= '0;
      r_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (stall_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_stall && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign ID_EX_OPcode = r_opcode;
  assign ID_EX_funct  = r_funct;
  assign ID_EX_rs     = r_rs;
  assign ID_EX_rt     = r_rt;
  assign ID_EX_rd     = r_rd;
  assign ID_EX_wreg   = r_wreg;
  assign ID_EX_rdata1 = r_rdata1;
  assign ID_EX_rdata2 = r_rdata2;
  assign ID_EX_imm    = r_imm;
  assign ID_EX_ctrl   = r_ctrl;
  assign ID_EX_valid  = r_valid;
  assign stall        = w_stall;
  assign pc_write     = ~w_stall;
  assign if_id_write  = ~w_stall;
  assign stall_count  = r_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: pass-through, load-use stalls, flush priority,
// async reset and stall counter saturation (second instance with CNT_W=2).
module tb_id_ex_stage;

  localparam int unsigned DATA_W = 32;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [8:0] C_RTYPE = 9'h10A; // RegWrite, RegDst, ALUOp=10
  localparam logic [8:0] C_LW    = 9'h1B0; // RegWrite, MemRead, MemtoReg, ALUSrc
  localparam logic [8:0] C_ADDI  = 9'h110; // RegWrite, ALUSrc

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  logic [5:0]        id_opcode;
  logic [5:0]        id_funct;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_rd;
  logic [DATA_W-1:0] id_rdata1;
  logic [DATA_W-1:0] id_rdata2;
  logic [DATA_W-1:0] id_imm;
  logic [8:0]        id_ctrl;
  logic              flush;
  logic              stall_cnt_clr;

  logic [5:0]        ID_EX_OPcode, ID_EX_funct;
  logic [4:0]        ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_wreg;
  logic [DATA_W-1:0] ID_EX_rdata1, ID_EX_rdata2, ID_EX_imm;
  logic [8:0]        ID_EX_ctrl;
  logic              ID_EX_valid, pc_write, if_id_write, stall;
  logic [15:0]       stall_count;

  logic [5:0]        s_OPcode, s_funct;
  logic [4:0]        s_rs, s_rt, s_rd, s_wreg;
  logic [DATA_W-1:0] s_rdata1, s_rdata2, s_imm;
  logic [8:0]        s_ctrl;
  logic              s_valid, s_pc_write, s_if_id_write, s_stall;
  logic [1:0]        s_stall_count;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .flush(flush), .stall_cnt_clr(stall_cnt_clr),
    .ID_EX_OPcode(ID_EX_OPcode), .ID_EX_funct(ID_EX_funct), .ID_EX_rs(ID_EX_rs),
    .ID_EX_rt(ID_EX_rt), .ID_EX_rd(ID_EX_rd), .ID_EX_wreg(ID_EX_wreg),
    .ID_EX_rdata1(ID_EX_rdata1), .ID_EX_rdata2(ID_EX_rdata2), .ID_EX_imm(ID_EX_imm),
    .ID_EX_ctrl(ID_EX_ctrl), .ID_EX_valid(ID_EX_valid), .pc_write(pc_write),
    .if_id_write(if_id_write), .stall(stall), .stall_count(stall_count)
  );

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .flush(flush), .stall_cnt_clr(stall_cnt_clr),
    .ID_EX_OPcode(s_OPcode), .ID_EX_funct(s_funct), .ID_EX_rs(s_rs),
    .ID_EX_rt(s_rt), .ID_EX_rd(s_rd), .ID_EX_wreg(s_wreg),
    .ID_EX_rdata1(s_rdata1), .ID_EX_rdata2(s_rdata2), .ID_EX_imm(s_imm),
    .ID_EX_ctrl(s_ctrl), .ID_EX_valid(s_valid), .pc_write(s_pc_write),
    .if_id_write(s_if_id_write), .stall(s_stall), .stall_count(s_stall_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [8:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm);
    id_valid = v; id_opcode = op; id_funct = fn; id_rs = rs; id_rt = rt; id_rd = rd;
    id_ctrl = ctrl; id_rdata1 = a; id_rdata2 = b; id_imm = imm;
    #1;
  endtask

  task automatic set_idle();
    set_id(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 9'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // lw $rt,0($1) presented and clocked into EX
  task automatic load_lw(input logic [4:0] rt);
    set_id(1'b1, OP_LW, 6'd0, 5'd1, rt, 5'd0, C_LW, 32'h100, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; stall_cnt_clr = 1'b0;
    set_idle();
    tick();
    rst_n = 1'b1;
    set_id(1'b1, OP_ADDI, 6'd0, 5'd1, 5'd4, 5'd0, C_ADDI, 32'h7, 32'h0, 32'h4);
    tick();
    ntests++;
    if (ID_EX_OPcode !== OP_ADDI || ID_EX_valid !== 1'b1) begin
      nfail++; $display("FAIL reset_preload: opcode=%h valid=%b want 08/1", ID_EX_OPcode, ID_EX_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    ntests++;
    if ({ID_EX_OPcode, ID_EX_funct, ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_wreg, ID_EX_ctrl, ID_EX_valid} !== '0 ||
        {ID_EX_rdata1, ID_EX_rdata2, ID_EX_imm} !== '0) begin
      nfail++; $display("FAIL reset_async: opcode=%h rs=%h rt=%h imm=%h ctrl=%h valid=%b want all 0",
                        ID_EX_OPcode, ID_EX_rs, ID_EX_rt, ID_EX_imm, ID_EX_ctrl, ID_EX_valid);
    end
    ntests++;
    if (pc_write !== 1'b1 || stall_count !== 16'd0 || s_stall_count !== 2'd0) begin
      nfail++; $display("FAIL reset_pc_cnt: pc_write=%b cnt=%0d cnt2=%0d want 1/0/0", pc_write, stall_count, s_stall_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_idle();
    tick();
  endtask

  task automatic test_passthrough();
    set_id(1'b1, OP_R, 6'h20, 5'd1, 5'd2, 5'd3, C_RTYPE, 32'h11, 32'h22, 32'h1820);
    ntests++;
    if (stall !== 1'b0) begin nfail++; $display("FAIL pass_stall: stall=%b want 0", stall); end
    tick();
    ntests++;
    if (ID_EX_rs !== 5'd1 || ID_EX_rt !== 5'd2 || ID_EX_rd !== 5'd3 || ID_EX_wreg !== 5'd3 ||
        ID_EX_valid !== 1'b1 || ID_EX_funct !== 6'h20 || ID_EX_OPcode !== OP_R) begin
      nfail++; $display("FAIL pass_fields: rs=%0d rt=%0d rd=%0d wreg=%0d valid=%b funct=%h want 1/2/3/3/1/20",
                        ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_wreg, ID_EX_valid, ID_EX_funct);
    end
    ntests++;
    if (ID_EX_rdata1 !== 32'h11 || ID_EX_rdata2 !== 32'h22 || ID_EX_imm !== 32'h1820 || ID_EX_ctrl !== C_RTYPE) begin
      nfail++; $display("FAIL pass_data: a=%h b=%h imm=%h ctrl=%h want 11/22/1820/10a",
                        ID_EX_rdata1, ID_EX_rdata2, ID_EX_imm, ID_EX_ctrl);
    end
    set_idle();
    tick();
    ntests++;
    if (ID_EX_valid !== 1'b0 || ID_EX_ctrl !== 9'd0) begin
      nfail++; $display("FAIL idle_bubble: valid=%b ctrl=%h want 0/0", ID_EX_valid, ID_EX_ctrl);
    end
  endtask

  task automatic test_load_use();
    load_lw(5'd5);
    ntests++;
    if (ID_EX_wreg !== 5'd5 || ID_EX_ctrl !== C_LW) begin
      nfail++; $display("FAIL lw_capture: wreg=%0d ctrl=%h want 5/1b0", ID_EX_wreg, ID_EX_ctrl);
    end
    set_id(1'b1, OP_R, 6'h20, 5'd5, 5'd2, 5'd6, C_RTYPE, 32'h0, 32'h0, 32'h0);
    ntests++;
    if (stall !== 1'b1 || pc_write !== 1'b0 || if_id_write !== 1'b0) begin
      nfail++; $display("FAIL lu_stall: stall=%b pc_write=%b if_id_write=%b want 1/0/0", stall, pc_write, if_id_write);
    end
    tick();
    ntests++;
    if (ID_EX_ctrl !== 9'd0 || ID_EX_valid !== 1'b0 || stall !== 1'b0 || pc_write !== 1'b1) begin
      nfail++; $display("FAIL lu_bubble: ctrl=%h valid=%b stall=%b pc_write=%b want 0/0/0/1",
                        ID_EX_ctrl, ID_EX_valid, stall, pc_write);
    end
    ntests++;
    if (stall_count !== 16'd1) begin nfail++; $display("FAIL lu_count: cnt=%0d want 1", stall_count); end
    tick();
    ntests++;
    if (ID_EX_rs !== 5'd5 || ID_EX_wreg !== 5'd6 || ID_EX_valid !== 1'b1 || stall_count !== 16'd1) begin
      nfail++; $display("FAIL lu_release: rs=%0d wreg=%0d valid=%b cnt=%0d want 5/6/1/1",
                        ID_EX_rs, ID_EX_wreg, ID_EX_valid, stall_count);
    end
    set_idle();
    tick();
  endtask

  task automatic test_no_false_stall();
    load_lw(5'd5);
    set_id(1'b1, OP_ADDI, 6'd0, 5'd7, 5'd5, 5'd0, C_ADDI, 32'h0, 32'h0, 32'h4);
    ntests++;
    if (stall !== 1'b0) begin nfail++; $display("FAIL nf_addi_rt: stall=%b want 0", stall); end
    set_id(1'b0, OP_R, 6'h20, 5'd5, 5'd5, 5'd6, C_RTYPE, 32'h0, 32'h0, 32'h0);
    ntests++;
    if (stall !== 1'b0) begin nfail++; $display("FAIL nf_invalid: stall=%b want 0", stall); end
    set_id(1'b1, OP_R, 6'h20, 5'd3, 5'd5, 5'd6, C_RTYPE, 32'h0, 32'h0, 32'h0);
    ntests++;
    if (stall !== 1'b1) begin nfail++; $display("FAIL rt_hazard: stall=%b want 1", stall); end
    set_id(1'b1, OP_ADDI, 6'd0, 5'd7, 5'd5, 5'd0, C_ADDI, 32'h0, 32'h0, 32'h4);
    tick();
    load_lw(5'd0);
    set_id(1'b1, OP_R, 6'h20, 5'd0, 5'd0, 5'd6, C_RTYPE, 32'h0, 32'h0, 32'h0);
    ntests++;
    if (stall !== 1'b0 || pc_write !== 1'b1) begin
      nfail++; $display("FAIL nf_reg0: stall=%b pc_write=%b want 0/1", stall, pc_write);
    end
    set_idle();
    tick();
  endtask

  task automatic test_flush();
    logic [15:0] c0;
    load_lw(5'd5);
    c0 = stall_count;
    set_id(1'b1, OP_R, 6'h20, 5'd5, 5'd5, 5'd6, C_RTYPE, 32'h5, 32'h5, 32'h0);
    flush = 1'b1;
    #1;
    ntests++;
    if (stall !== 1'b0 || pc_write !== 1'b1 || if_id_write !== 1'b1) begin
      nfail++; $display("FAIL flush_stall: stall=%b pc_write=%b if_id_write=%b want 0/1/1", stall, pc_write, if_id_write);
    end
    tick();
    flush = 1'b0;
    ntests++;
    if (ID_EX_ctrl !== 9'd0 || ID_EX_valid !== 1'b0 || ID_EX_rs !== 5'd0 || stall_count !== c0) begin
      nfail++; $display("FAIL flush_bubble: ctrl=%h valid=%b rs=%0d cnt=%0d want 0/0/0/%0d",
                        ID_EX_ctrl, ID_EX_valid, ID_EX_rs, stall_count, c0);
    end
    set_idle();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] c0;
    c0 = stall_count;
    load_lw(5'd5);
    set_id(1'b1, OP_LW, 6'd0, 5'd5, 5'd6, 5'd0, C_LW, 32'h0, 32'h0, 32'h0);
    ntests++;
    if (stall !== 1'b1) begin nfail++; $display("FAIL b2b_stall1: stall=%b want 1", stall); end
    tick();
    tick();
    ntests++;
    if (ID_EX_rt !== 5'd6 || ID_EX_ctrl !== C_LW || ID_EX_valid !== 1'b1) begin
      nfail++; $display("FAIL b2b_lw2: rt=%0d ctrl=%h valid=%b want 6/1b0/1", ID_EX_rt, ID_EX_ctrl, ID_EX_valid);
    end
    set_id(1'b1, OP_R, 6'h20, 5'd6, 5'd0, 5'd7, C_RTYPE, 32'h0, 32'h0, 32'h0);
    ntests++;
    if (stall !== 1'b1) begin nfail++; $display("FAIL b2b_stall2: stall=%b want 1", stall); end
    tick();
    ntests++;
    if (stall !== 1'b0 || stall_count !== c0 + 16'd2) begin
      nfail++; $display("FAIL b2b_count: stall=%b cnt=%0d want 0/%0d", stall, stall_count, c0 + 16'd2);
    end
    tick();
    ntests++;
    if (ID_EX_wreg !== 5'd7 || ID_EX_valid !== 1'b1) begin
      nfail++; $display("FAIL b2b_use: wreg=%0d valid=%b want 7/1", ID_EX_wreg, ID_EX_valid);
    end
    set_idle();
    tick();
  endtask

  task automatic test_counter();
    logic [1:0] exp2;
    stall_cnt_clr = 1'b1;
    tick();
    stall_cnt_clr = 1'b0;
    ntests++;
    if (s_stall_count !== 2'd0 || stall_count !== 16'd0) begin
      nfail++; $display("FAIL cnt_clr: cnt2=%0d cnt=%0d want 0/0", s_stall_count, stall_count);
    end
    for (int unsigned k = 1; k <= 5; k++) begin
      load_lw(5'd9);
      set_id(1'b1, OP_R, 6'h20, 5'd9, 5'd1, 5'd2, C_RTYPE, 32'h0, 32'h0, 32'h0);
      tick();
      exp2 = (k >= 3) ? 2'd3 : 2'(k);
      ntests++;
      if (s_stall_count !== exp2 || stall_count !== 16'(k)) begin
        nfail++; $display("FAIL cnt_sat_%0d: cnt2=%0d cnt=%0d want %0d/%0d", k, s_stall_count, stall_count, exp2, k);
      end
      set_idle();
    end
    load_lw(5'd9);
    set_id(1'b1, OP_R, 6'h20, 5'd9, 5'd1, 5'd2, C_RTYPE, 32'h0, 32'h0, 32'h0);
    stall_cnt_clr = 1'b1;
    #1;
    ntests++;
    if (stall !== 1'b1) begin nfail++; $display("FAIL cnt_clr_stall: stall=%b want 1", stall); end
    tick();
    stall_cnt_clr = 1'b0;
    ntests++;
    if (s_stall_count !== 2'd0 || stall_count !== 16'd0) begin
      nfail++; $display("FAIL cnt_clr_prio: cnt2=%0d cnt=%0d want 0/0", s_stall_count, stall_count);
    end
    set_idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load_use();
    test_no_false_stall();
    test_flush();
    test_back_to_back();
    test_counter();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
